// File: rtl/nabp_filtered_ram_swap_control_pkg.sv
// Shared widths, derived constants and fill FSM states for the filtered line
// double buffer.
package nabp_filtered_ram_swap_control_pkg;

  localparam int kAngleLength        = 9;
  localparam int kSLength            = 8;
  localparam int kProjectionLineSize = 128;
  localparam int kFilteredDataLength = 16;
  localparam int kFilterDelay        = 4;

  // Host RAM lookup (1 cycle) plus filter latency.
  localparam int kWriteDelay = 1 + kFilterDelay;
  localparam int kAddrBits   = $clog2(kProjectionLineSize);
  localparam int kDrainBits  = $clog2(kWriteDelay);

  localparam logic [kSLength-1:0]   kLastS     = kSLength'(kProjectionLineSize - 1);
  localparam logic [kDrainBits-1:0] kDrainLoad = kDrainBits'(kFilterDelay);

  typedef enum logic [2:0] {
    REQ,
    SWEEP,
    DRAIN,
    FULL,
    DONE
  } fill_state_e;

  function automatic logic addr_in_range(input logic [kSLength-1:0] addr);
    return int'(addr) < kProjectionLineSize;
  endfunction

endpackage

// File: rtl/nabp_filtered_ram_swap_control_if.sv
// Host-side and processing-side signals of the filtered line double buffer.
// master = host/processing environment, slave = the swap controller.
interface nabp_filtered_ram_swap_control_if;
  import nabp_filtered_ram_swap_control_pkg::*;

  logic        [kAngleLength-1:0]        hs_angle;
  logic                                  hs_has_next_angle;
  logic                                  hs_next_angle_ack;
  logic signed [kFilteredDataLength-1:0] hs_val;
  logic        [kSLength-1:0]            pr0_s_val;
  logic        [kSLength-1:0]            pr1_s_val;
  logic                                  pr_next_angle;
  logic        [kSLength-1:0]            hs_s_val;
  logic                                  hs_next_angle;
  logic        [kAngleLength-1:0]        pr_angle;
  logic                                  pr_next_angle_ack;
  logic signed [kFilteredDataLength-1:0] pr0_val;
  logic signed [kFilteredDataLength-1:0] pr1_val;

  modport master (
    output hs_angle, hs_has_next_angle, hs_next_angle_ack, hs_val,
           pr0_s_val, pr1_s_val, pr_next_angle,
    input  hs_s_val, hs_next_angle, pr_angle, pr_next_angle_ack, pr0_val, pr1_val
  );

  modport slave (
    input  hs_angle, hs_has_next_angle, hs_next_angle_ack, hs_val,
           pr0_s_val, pr1_s_val, pr_next_angle,
    output hs_s_val, hs_next_angle, pr_angle, pr_next_angle_ack, pr0_val, pr1_val
  );

endinterface

// File: rtl/nabp_filtered_ram_swap_control_filtered_ram_bank.sv
// One filtered line bank: a write port and two synchronous read ports.
// Addresses past the end of the line read back as zero.
module filtered_ram_bank
  import nabp_filtered_ram_swap_control_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  we_i,
  input  logic        [kAddrBits-1:0]           waddr_i,
  input  logic signed [kFilteredDataLength-1:0] wdata_i,
  input  logic        [kSLength-1:0]            raddr0_i,
  input  logic        [kSLength-1:0]            raddr1_i,
  output logic signed [kFilteredDataLength-1:0] rdata0_o,
  output logic signed [kFilteredDataLength-1:0] rdata1_o
);

  logic signed [kFilteredDataLength-1:0] mem_q [kProjectionLineSize];
  logic signed [kFilteredDataLength-1:0] rdata0_q, rdata1_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rdata0_q <= addr_in_range(raddr0_i) ? mem_q[raddr0_i[kAddrBits-1:0]] : '0;
      rdata1_q <= addr_in_range(raddr1_i) ? mem_q[raddr1_i[kAddrBits-1:0]] : '0;
    end
  end

  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

// File: rtl/nabp_filtered_ram_swap_control.sv
// Double-buffered filtered line store: fills one bank from the host filter
// while the processing side reads the other, swapping on request.
//   state | meaning
//   REQ   | asking host for the next angle
//   SWEEP | stepping host address 0..N-1
//   DRAIN | waiting for the last filtered sample to land
//   FULL  | line complete, waiting for a swap
//   DONE  | last angle handed over, idle until reset
module nabp_filtered_ram_swap_control
  import nabp_filtered_ram_swap_control_pkg::*;
(
  input logic                            clk,
  input logic                            reset_n,
  nabp_filtered_ram_swap_control_if.slave bus
);

  fill_state_e                 state_q, state_d;
  logic [kSLength-1:0]         s_q, s_d;
  logic [kDrainBits-1:0]       drain_q, drain_d;
  logic [kAngleLength-1:0]     fill_angle_q, fill_angle_d;
  logic [kAngleLength-1:0]     pr_angle_q, pr_angle_d;
  logic                        last_n_q, last_n_d;
  logic                        bank_sel_q, bank_sel_d;
  logic                        armed_q, armed_d;
  logic                        ack_q, ack_d;
  logic                        next_angle_q, next_angle_d;
  logic                        swap;

  logic [kAddrBits-1:0]        waddr_pipe_q [kWriteDelay];
  logic [kWriteDelay-1:0]      wvalid_pipe_q;
  logic                        wen;

  logic signed [kFilteredDataLength-1:0] b0_rd0, b0_rd1, b1_rd0, b1_rd1;

  assign swap = (state_q == FULL) && bus.pr_next_angle && armed_q;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    drain_d      = drain_q;
    fill_angle_d = fill_angle_q;
    last_n_d     = last_n_q;
    bank_sel_d   = bank_sel_q;
    pr_angle_d   = pr_angle_q;
    armed_d      = (armed_q || !bus.pr_next_angle) && !swap;
    ack_d        = swap;
    unique case (state_q)
      REQ: begin
        if (bus.hs_next_angle_ack) begin
          fill_angle_d = bus.hs_angle;
          last_n_d     = bus.hs_has_next_angle;
          s_d          = '0;
          state_d      = SWEEP;
        end
      end
      SWEEP: begin
        if (s_q == kLastS) begin
          s_d     = '0;
          drain_d = kDrainLoad;
          state_d = DRAIN;
        end else begin
          s_d = s_q + kSLength'(1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = FULL;
        else               drain_d = drain_q - kDrainBits'(1);
      end
      FULL: begin
        if (swap) begin
          bank_sel_d = !bank_sel_q;
          pr_angle_d = fill_angle_q;
          state_d    = last_n_q ? REQ : DONE;
        end
      end
      DONE: ;
      default: state_d = REQ;
    endcase
    next_angle_d = (state_d == REQ) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q       <= REQ;
      s_q           <= '0;
      drain_q       <= '0;
      fill_angle_q  <= '0;
      pr_angle_q    <= '0;
      last_n_q      <= 1'b0;
      bank_sel_q    <= 1'b0;
      armed_q       <= 1'b1;
      ack_q         <= 1'b0;
      next_angle_q  <= 1'b1;
      wvalid_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      drain_q       <= drain_d;
      fill_angle_q  <= fill_angle_d;
      pr_angle_q    <= pr_angle_d;
      last_n_q      <= last_n_d;
      bank_sel_q    <= bank_sel_d;
      armed_q       <= armed_d;
      ack_q         <= ack_d;
      next_angle_q  <= next_angle_d;
      wvalid_pipe_q <= {wvalid_pipe_q[kWriteDelay-2:0], state_q == SWEEP};
    end
  end

  // Address rides alongside the filter latency; only the valid bit needs reset.
  always_ff @(posedge clk) begin
    waddr_pipe_q[0] <= s_q[kAddrBits-1:0];
    for (int i = 1; i < kWriteDelay; i++) waddr_pipe_q[i] <= waddr_pipe_q[i-1];
  end

  assign wen = wvalid_pipe_q[kWriteDelay-1];

  filtered_ram_bank u_bank0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .we_i     (wen && !bank_sel_q),
    .waddr_i  (waddr_pipe_q[kWriteDelay-1]),
    .wdata_i  (bus.hs_val),
    .raddr0_i (bus.pr0_s_val),
    .raddr1_i (bus.pr1_s_val),
    .rdata0_o (b0_rd0),
    .rdata1_o (b0_rd1)
  );

  filtered_ram_bank u_bank1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .we_i     (wen && bank_sel_q),
    .waddr_i  (waddr_pipe_q[kWriteDelay-1]),
    .wdata_i  (bus.hs_val),
    .raddr0_i (bus.pr0_s_val),
    .raddr1_i (bus.pr1_s_val),
    .rdata0_o (b1_rd0),
    .rdata1_o (b1_rd1)
  );

  assign bus.hs_s_val          = s_q;
  assign bus.hs_next_angle     = next_angle_q;
  assign bus.pr_angle          = pr_angle_q;
  assign bus.pr_next_angle_ack = ack_q;
  assign bus.pr0_val           = bank_sel_q ? b0_rd0 : b1_rd0;
  assign bus.pr1_val           = bank_sel_q ? b0_rd1 : b1_rd1;

endmodule

// File: tb/tb_nabp_filtered_ram_swap_control.sv
// Bench for the filtered line double buffer: a host RAM + filter model feeds
// s + angle, and every read is compared with the line expected for pr_angle.
module tb_nabp_filtered_ram_swap_control;
  import nabp_filtered_ram_swap_control_pkg::*;

  localparam int kN          = kProjectionLineSize;
  localparam int kFillToSwap = kN + 1 + kFilterDelay + 1;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   ack_pulses = 0;
  int   host_angle = 0;
  int   angle_q[$];

  nabp_filtered_ram_swap_control_if bus ();

  nabp_filtered_ram_swap_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Host sinogram RAM (1-cycle lookup) followed by the filter delay line.
  logic [kFilteredDataLength-1:0] look_q;
  logic [kFilteredDataLength-1:0] filt_q [kFilterDelay];
  always @(posedge clk) begin
    look_q    <= kFilteredDataLength'(int'(bus.hs_s_val) + host_angle);
    filt_q[0] <= look_q;
    for (int i = 1; i < kFilterDelay; i++) filt_q[i] <= filt_q[i-1];
  end
  assign bus.hs_val = filt_q[kFilterDelay-1];

  always @(negedge clk) if (bus.pr_next_angle_ack === 1'b1) ack_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_val(input int addr, input int angle);
    return (addr < kN) ? addr + angle : 0;
  endfunction

  task automatic check_reset_values();
    check_eq("rst_hs_next_angle", int'(bus.hs_next_angle), 1);
    check_eq("rst_hs_s_val", int'(bus.hs_s_val), 0);
    check_eq("rst_pr_angle", int'(bus.pr_angle), 0);
    check_eq("rst_pr_ack", int'(bus.pr_next_angle_ack), 0);
    check_eq("rst_pr0_val", int'(bus.pr0_val), 0);
    check_eq("rst_pr1_val", int'(bus.pr1_val), 0);
  endtask

  task automatic pulse_reset();
    bus.pr_next_angle     = 1'b0;
    bus.hs_next_angle_ack = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values();
    reset_n = 1'b0;
  endtask

  task automatic sweep_check();
    int good = 0;
    for (int i = 0; i < kN; i++) begin
      if (int'(bus.hs_s_val) == i) good++;
      @(negedge clk);
    end
    check_eq("sweep_steps", good, kN);
  endtask

  task automatic host_offer(input int angle, input bit has_next);
    int w = 0;
    while (bus.hs_next_angle !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check_eq("hs_next_angle_req", int'(bus.hs_next_angle), 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.hs_angle          = kAngleLength'(angle);
    bus.hs_has_next_angle = has_next;
    bus.hs_next_angle_ack = 1'b1;
    host_angle            = angle;
    angle_q.push_back(angle);
    @(negedge clk);
    bus.hs_next_angle_ack = 1'b0;
    check_eq("hs_next_angle_drop", int'(bus.hs_next_angle), 0);
    sweep_check();
  endtask

  task automatic swap_checks(input int angle);
    check_eq("swap_ack_seen", int'(bus.pr_next_angle_ack), 1);
    check_eq("pr_angle", int'(bus.pr_angle), angle);
    check_eq("swap_rd_new_bank", int'(bus.pr0_val), exp_val(5, angle));
    check_eq("swap_rd_oor", int'(bus.pr1_val), 0);
    @(negedge clk);
    check_eq("ack_one_cycle", int'(bus.pr_next_angle_ack), 0);
    repeat (3) @(negedge clk);
    check_eq("ack_no_repeat", int'(bus.pr_next_angle_ack), 0);
    bus.pr_next_angle = 1'b0;
  endtask

  task automatic pr_swap(input int angle);
    int w = 0;
    bus.pr0_s_val     = 8'd5;
    bus.pr1_s_val     = 8'd200;
    bus.pr_next_angle = 1'b1;
    @(negedge clk);
    while (bus.pr_next_angle_ack !== 1'b1 && w < 600) begin
      @(negedge clk);
      w++;
    end
    swap_checks(angle);
  endtask

  task automatic pr_read_pair(input int a0, input int a1, input int angle);
    bus.pr0_s_val = kSLength'(a0);
    bus.pr1_s_val = kSLength'(a1);
    @(negedge clk);
    check_eq("rd_pr0", int'(bus.pr0_val), exp_val(a0, angle));
    check_eq("rd_pr1", int'(bus.pr1_val), exp_val(a1, angle));
  endtask

  task automatic pr_read_line(input int angle);
    for (int s = 0; s < kN; s++) pr_read_pair(s, int'($urandom_range(0, 255)), angle);
  endtask

  task automatic host_thread();
    host_offer(20, 1'b1);
    host_offer(40, 1'b1);
    host_offer(60, 1'b1);
    host_offer(80, 1'b0);
  endtask

  task automatic pr_thread();
    int cur = 0;
    int a;
    int w;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (angle_q.size() == 0 && w < 1000) begin
        @(negedge clk);
        w++;
      end
      check_eq("angle_offered", angle_q.size(), 1);
      if (angle_q.size() == 0) return;
      a = angle_q.pop_front();
      if (k == 1) begin
        repeat (200) @(negedge clk);
        check_eq("hold_hs_next_angle", int'(bus.hs_next_angle), 0);
        check_eq("hold_pr_angle", int'(bus.pr_angle), cur);
        pr_read_pair(5, 100, cur);
      end else begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      pr_swap(a);
      pr_read_line(a);
      cur = a;
    end
  endtask

  initial begin
    int edges;
    reset_n               = 1'b1;
    bus.hs_angle          = '0;
    bus.hs_has_next_angle = 1'b0;
    bus.hs_next_angle_ack = 1'b0;
    bus.pr0_s_val         = '0;
    bus.pr1_s_val         = '0;
    bus.pr_next_angle     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset_n = 1'b0;
    @(negedge clk);

    // First fill with the swap request held from the ack: measures fill latency.
    check_eq("req_after_reset", int'(bus.hs_next_angle), 1);
    bus.hs_angle          = '0;
    bus.hs_has_next_angle = 1'b1;
    bus.hs_next_angle_ack = 1'b1;
    bus.pr_next_angle     = 1'b1;
    bus.pr0_s_val         = 8'd5;
    bus.pr1_s_val         = 8'd200;
    host_angle            = 0;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    bus.hs_next_angle_ack = 1'b0;
    check_eq("hs_next_angle_drop", int'(bus.hs_next_angle), 0);
    for (int i = 0; i < kN; i++) begin
      check_eq("sweep_s", int'(bus.hs_s_val), i);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    while (bus.pr_next_angle_ack !== 1'b1 && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_eq("fill_latency", edges, kFillToSwap);
    swap_checks(0);
    pr_read_line(0);
    pr_read_pair(5, 100, 0);
    pr_read_pair(127, 128, 0);
    pr_read_pair(0, 255, 0);

    fork
      host_thread();
      pr_thread();
    join

    repeat (3) @(negedge clk);
    check_eq("done_hs_next_angle", int'(bus.hs_next_angle), 1);
    check_eq("ack_count_5", ack_pulses, 5);

    // In DONE an acked angle must not start a fill, so no swap can follow.
    bus.hs_angle          = 9'd300;
    bus.hs_has_next_angle = 1'b1;
    bus.hs_next_angle_ack = 1'b1;
    @(negedge clk);
    bus.hs_next_angle_ack = 1'b0;
    bus.pr_next_angle     = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("done_no_sweep", int'(bus.hs_s_val), 0);
    check_eq("done_pr_angle", int'(bus.pr_angle), 80);
    check_eq("done_hs_next_angle_hold", int'(bus.hs_next_angle), 1);
    check_eq("done_no_swap", ack_pulses, 5);
    bus.pr_next_angle = 1'b0;
    pr_read_pair(5, 100, 80);

    pulse_reset();
    @(negedge clk);
    bus.hs_angle          = 9'd33;
    bus.hs_has_next_angle = 1'b1;
    bus.hs_next_angle_ack = 1'b1;
    host_angle            = 33;
    @(negedge clk);
    bus.hs_next_angle_ack = 1'b0;
    repeat (50) @(negedge clk);
    check_eq("mid_sweep_s", int'(bus.hs_s_val), 50);
    pulse_reset();
    angle_q.delete();
    host_offer(44, 1'b1);
    pr_swap(44);
    pr_read_line(44);
    repeat (2) @(negedge clk);
    check_eq("ack_count_6", ack_pulses, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
